biu_mem_arbiter: RTL and testbench
==================================

# biu_mem_arbiter

Two-requester arbiter that shares a single bus-interface-unit (BIU) memory port between the core's instruction-fetch path and data-memory path. It sits between the RV12 core (`if_*` / `dmem_*` side) and the BIU. It allows one outstanding transfer at a time and gives data accesses priority, bounded by an anti-starvation counter. It also handles instruction flushes while a fetch is in flight.

## Interface
Parameters:
- `XLEN`, 32, data width.
- `PLEN`, 32, physical address width.
- `STARVE_MAX`, 4, maximum consecutive data grants while a fetch is pending; range 1..15.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `i_req`  in  1  fetch request; held until `i_ack` or `i_err`.
- `i_adr`  in  PLEN  fetch address.
- `i_flush`  in  1  discard the current or pending fetch.
- `i_ack`, `i_err`  out  1  fetch done / fetch error.
- `i_q`  out  XLEN  fetch data; valid with `i_ack`.
- `d_req`  in  1  data request; held until `d_ack` or `d_err`.
- `d_adr`  in  PLEN  data address.
- `d_d`  in  XLEN  write data.
- `d_we`  in  1  write enable.
- `d_size`  in  biu_size_t  access size.
- `d_ack`, `d_err`  out  1  data done / data error.
- `d_q`  out  XLEN  read data; valid with `d_ack`.
- `biu_req`  out  1  downstream request.
- `biu_adr`  out  PLEN  downstream address.
- `biu_d`  out  XLEN  downstream write data.
- `biu_we`  out  1  downstream write enable.
- `biu_size`  out  biu_size_t  downstream access size.
- `biu_ack`, `biu_err`  in  1  downstream completion.
- `biu_q`  in  XLEN  downstream read data.

## Operation
- **FSM states:** IDLE, BUSY_I, BUSY_D.
- **Arbitration in IDLE**, evaluated at each rising edge:
  - Only `d_req`: go to BUSY_D.
  - Only `i_req` with `i_flush`=0: go to BUSY_I.
  - Both requesting: BUSY_I if `streak==STARVE_MAX`, otherwise BUSY_D.
  - `i_req` together with `i_flush`=1 counts as no fetch request.
- **Grant capture:** on grant, register address, data, we and size. For a fetch grant, `biu_we`=0, `biu_size`=WORD and `biu_d`=0. These registers hold stable throughout the BUSY state.
- **`biu_req`** = 1 exactly while in BUSY_I or BUSY_D (Moore output).
- **Completion:** `biu_ack` or `biu_err` in a BUSY state returns the FSM to IDLE. Both asserted together are treated as an error.
- **Response routing**, combinational, in the same cycle as `biu_ack`/`biu_err`:
  - BUSY_D: `d_ack` = `biu_ack` & ~`biu_err`; `d_err` = `biu_err`; `d_q` = `biu_q`.
  - BUSY_I: `i_ack` = `biu_ack` & ~`biu_err` & ~`drop`; `i_err` = `biu_err` & ~`drop`; `i_q` = `biu_q`.
  - All other ack/err outputs are 0.
- **Starvation counter** `streak` (4 bits):
  - On a D grant while `i_req` & ~`i_flush`: increment, saturating at `STARVE_MAX`.
  - On a D grant with no fetch pending: clear.
  - On an I grant: clear.
- **Flush:**
  - `i_flush` in BUSY_I sets `drop`. The downstream transfer still completes, but no `i_ack`/`i_err` is issued.
  - `drop` clears when the FSM leaves BUSY_I.
  - `i_flush` in BUSY_D or IDLE does not touch `drop`.
- **Aborts:** none. A downstream transfer is never aborted.

## Timing
- **Reset values:** state IDLE. `biu_req`, `biu_we`, `biu_adr`, `biu_d`, `streak` and `drop` are 0. `biu_size` is the biu_size_t zero encoding. `i_ack`, `i_err`, `d_ack` and `d_err` are 0.
- **Request latency:** a request sampled high in IDLE at edge N gives `biu_req`=1 in cycle N+1.
- **Ack latency:** `biu_ack` in cycle M gives the requester's ack in cycle M (zero-cycle pass-through). The FSM is IDLE in cycle M+1.
- **Minimum spacing:** `biu_req` is low for at least one cycle between transfers. Minimum transfer period is 2 + BIU latency cycles.
- **Requester contract:** a request still high in the cycle after its ack is a new request.
- **Mid-operation reset:** `rstn` low at any time forces the reset values immediately. Recovery of the BIU is the downstream's responsibility.
- **Flush/ack collision:** `i_flush` asserted in the same cycle as `biu_ack` in BUSY_I still suppresses `i_ack`.

## Test plan
- **Single fetch:** reset; `i_req`=1, `i_adr`=0x200; BIU acks after 3 cycles with `biu_q`=0x00000013 -> `biu_req` high from cycle 1; `biu_adr`=0x200; `biu_we`=0; `i_ack`=1 with `i_q`=0x13 in the ack cycle; `biu_req` low the next cycle.
- **Data priority:** `i_req` and `d_req` (write, 0x1000, 0xDEADBEEF) high together from IDLE -> D granted first with `biu_we`=1 and `biu_d`=0xDEADBEEF; I granted after `d_ack`.
- **Anti-starvation:** `i_req` held high while `d_req` re-requests every cycle after each ack, `STARVE_MAX`=4 -> exactly 4 D transfers, then 1 I transfer; `streak` returns to 0.
- **Flush in flight:** BUSY_I at 0x204; `i_flush` pulsed 1 cycle before `biu_ack` -> `i_ack`=0 and `i_err`=0; FSM returns to IDLE; the next fetch at 0x300 acks normally.
- **Error path:** data read to 0x4; BIU asserts `biu_err` and `biu_ack` together -> `d_err`=1, `d_ack`=0; FSM returns to IDLE.
- **Async reset:** assert `rstn`=0 mid-BUSY_D between clock edges -> `biu_req` drops immediately and all ack/err outputs read 0; after release, a fresh request is granted normally.

Source files
------------

// File: rtl/biu_mem_arbiter.sv
// Shares one BIU memory port between instruction fetch and data access.
// One transfer in flight; data has priority, bounded by a starvation streak.
package biu_pkg;
  typedef enum logic [2:0] {
    BYTE  = 3'd0,
    HWORD = 3'd1,
    WORD  = 3'd2,
    DWORD = 3'd3,
    QWORD = 3'd4
  } biu_size_t;
endpackage

module biu_mem_arbiter
  import biu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int PLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_req,
  input  logic [PLEN-1:0] i_adr,
  input  logic            i_flush,
  output logic            i_ack,
  output logic            i_err,
  output logic [XLEN-1:0] i_q,
  input  logic            d_req,
  input  logic [PLEN-1:0] d_adr,
  input  logic [XLEN-1:0] d_d,
  input  logic            d_we,
  input  biu_size_t       d_size,
  output logic            d_ack,
  output logic            d_err,
  output logic [XLEN-1:0] d_q,
  output logic            biu_req,
  output logic [PLEN-1:0] biu_adr,
  output logic [XLEN-1:0] biu_d,
  output logic            biu_we,
  output biu_size_t       biu_size,
  input  logic            biu_ack,
  input  logic            biu_err,
  input  logic [XLEN-1:0] biu_q
);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  typedef struct packed {
    logic [PLEN-1:0] adr;
    logic [XLEN-1:0] d;
    logic            we;
    biu_size_t       size;
  } xfer_t;

  state_t     state, nxt;
  xfer_t      xfer;
  logic [3:0] streak;
  logic       drop;
  logic       fetch_pend, grant_i, grant_d, done, kill;

  // a flushed fetch request is not a request at all
  assign fetch_pend = i_req & ~i_flush;
  assign done       = biu_ack | biu_err;
  assign kill       = drop | i_flush;

  always_comb begin
    nxt     = state;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!fetch_pend || streak != SMAX)) begin
          grant_d = 1'b1;
          nxt     = BUSY_D;
        end else if (fetch_pend) begin
          grant_i = 1'b1;
          nxt     = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: if (done) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      xfer <= '0;
    end else if (grant_d) begin
      xfer <= '{adr: d_adr, d: d_d, we: d_we, size: d_size};
    end else if (grant_i) begin
      xfer <= '{adr: i_adr, d: '0, we: 1'b0, size: WORD};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      streak <= 4'd0;
    end else if (grant_d) begin
      if (!fetch_pend)       streak <= 4'd0;
      else if (streak < SMAX) streak <= streak + 4'd1;
    end else if (grant_i) begin
      streak <= 4'd0;
    end
  end

  // drop survives until the flushed fetch drains out of BUSY_I
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                drop <= 1'b0;
    else if (state != BUSY_I) drop <= 1'b0;
    else if (done)            drop <= 1'b0;
    else if (i_flush)         drop <= 1'b1;
  end

  always_comb begin
    biu_req  = (state != IDLE);
    biu_adr  = xfer.adr;
    biu_d    = xfer.d;
    biu_we   = xfer.we;
    biu_size = xfer.size;
    d_ack    = (state == BUSY_D) & biu_ack & ~biu_err;
    d_err    = (state == BUSY_D) & biu_err;
    d_q      = biu_q;
    i_ack    = (state == BUSY_I) & biu_ack & ~biu_err & ~kill;
    i_err    = (state == BUSY_I) & biu_err & ~kill;
    i_q      = biu_q;
  end
endmodule

// File: tb/tb_biu_mem_arbiter.sv
// Directed scenarios plus randomized traffic, checked against a transfer-level model.
module tb_biu_mem_arbiter;
  import biu_pkg::*;

  localparam int SMAX = 4;

  logic        clk, rstn;
  logic        i_req, i_flush, i_ack, i_err;
  logic [31:0] i_adr, i_q;
  logic        d_req, d_we, d_ack, d_err;
  logic [31:0] d_adr, d_d, d_q;
  biu_size_t   d_size, biu_size;
  logic        biu_req, biu_we, biu_ack, biu_err;
  logic [31:0] biu_adr, biu_d, biu_q;

  int checks = 0;
  int errors = 0;

  biu_mem_arbiter #(.XLEN(32), .PLEN(32), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rstn(rstn),
    .i_req(i_req), .i_adr(i_adr), .i_flush(i_flush),
    .i_ack(i_ack), .i_err(i_err), .i_q(i_q),
    .d_req(d_req), .d_adr(d_adr), .d_d(d_d), .d_we(d_we), .d_size(d_size),
    .d_ack(d_ack), .d_err(d_err), .d_q(d_q),
    .biu_req(biu_req), .biu_adr(biu_adr), .biu_d(biu_d), .biu_we(biu_we),
    .biu_size(biu_size), .biu_ack(biu_ack), .biu_err(biu_err), .biu_q(biu_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Transfer-level model: who owns the port, what it asked for, how many
  // data grants in a row have bypassed a waiting fetch, and whether the fetch in flight is discarded.
  int          m_own;   // 0 none, 1 fetch, 2 data
  int          m_streak;
  bit          m_drop;
  logic [31:0] m_adr, m_d;
  logic        m_we;
  logic [2:0]  m_size;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_own <= 0; m_streak <= 0; m_drop <= 1'b0;
      m_adr <= '0; m_d <= '0; m_we <= 1'b0; m_size <= 3'd0;
    end else if (m_own == 0) begin
      if (d_req && (!(i_req && !i_flush) || m_streak != SMAX)) begin
        m_own <= 2;
        m_adr <= d_adr; m_d <= d_d; m_we <= d_we; m_size <= 3'(d_size);
        m_streak <= (i_req && !i_flush) ? ((m_streak < SMAX) ? m_streak + 1 : SMAX) : 0;
      end else if (i_req && !i_flush) begin
        m_own <= 1;
        m_adr <= i_adr; m_d <= '0; m_we <= 1'b0; m_size <= 3'(WORD);
        m_streak <= 0;
      end
    end else begin
      if (m_own == 1 && i_flush) m_drop <= 1'b1;
      if (biu_ack || biu_err) begin
        m_own  <= 0;
        m_drop <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    #3;
    chk("biu_req", 32'(biu_req), 32'(m_own != 0));
    chk("streak", 32'(dut.streak), 32'(m_streak));
    if (m_own != 0) begin
      chk("biu_adr", biu_adr, m_adr);
      chk("biu_d", biu_d, m_d);
      chk("biu_we", 32'(biu_we), 32'(m_we));
      chk("biu_size", 32'(biu_size), 32'(m_size));
    end
    chk("d_ack", 32'(d_ack), 32'(m_own == 2 && biu_ack && !biu_err));
    chk("d_err", 32'(d_err), 32'(m_own == 2 && biu_err));
    chk("i_ack", 32'(i_ack), 32'(m_own == 1 && biu_ack && !biu_err && !m_drop && !i_flush));
    chk("i_err", 32'(i_err), 32'(m_own == 1 && biu_err && !m_drop && !i_flush));
    if (d_ack) chk("d_q", d_q, biu_q);
    if (i_ack) chk("i_q", i_q, biu_q);
  end

  // wait (bounded) for a transfer, hold it lat cycles, then drive the response
  task automatic serve(input int lat, input logic a, input logic e, input logic [31:0] q);
    int n = 0;
    while (!biu_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!biu_req) chk("serve_timeout", 32'(biu_req), 32'd1);
    repeat (lat) @(negedge clk);
    biu_ack = a; biu_err = e; biu_q = q;
    #1;
  endtask

  task automatic release_biu();
    @(negedge clk);
    biu_ack = 1'b0; biu_err = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  int seq_d;
  bit seq_ok;
  int bcnt;
  bit saw_i, saw_d, saw_f;

  initial begin
    rstn = 1'b0; i_req = 0; i_adr = 0; i_flush = 0;
    d_req = 0; d_adr = 0; d_d = 0; d_we = 0; d_size = BYTE;
    biu_ack = 0; biu_err = 0; biu_q = 0;
    @(negedge clk); #1;
    chk("rst_biu_req", 32'(biu_req), 32'd0);
    chk("rst_biu_adr", biu_adr, 32'd0);
    chk("rst_biu_d", biu_d, 32'd0);
    chk("rst_biu_we", 32'(biu_we), 32'd0);
    chk("rst_biu_size", 32'(biu_size), 32'd0);
    chk("rst_drop", 32'(dut.drop), 32'd0);
    @(negedge clk); rstn = 1'b1;

    // single fetch
    @(negedge clk); i_req = 1; i_adr = 32'h200;
    @(negedge clk); #1;
    chk("sf_req", 32'(biu_req), 32'd1);
    chk("sf_adr", biu_adr, 32'h200);
    chk("sf_we", 32'(biu_we), 32'd0);
    serve(2, 1, 0, 32'h13);
    chk("sf_ack", 32'(i_ack), 32'd1);
    chk("sf_q", i_q, 32'h13);
    release_biu(); i_req = 0; #1;
    chk("sf_req_low", 32'(biu_req), 32'd0);

    // data priority over a simultaneous fetch
    @(negedge clk);
    i_req = 1; i_adr = 32'h400;
    d_req = 1; d_adr = 32'h1000; d_d = 32'hDEADBEEF; d_we = 1; d_size = WORD;
    serve(1, 1, 0, 0);
    chk("dp_adr", biu_adr, 32'h1000);
    chk("dp_we", 32'(biu_we), 32'd1);
    chk("dp_d", biu_d, 32'hDEADBEEF);
    chk("dp_dack", 32'(d_ack), 32'd1);
    release_biu(); d_req = 0;
    serve(1, 1, 0, 32'h55);
    chk("dp_iadr", biu_adr, 32'h400);
    chk("dp_iack", 32'(i_ack), 32'd1);
    release_biu(); i_req = 0;

    // anti-starvation: 4 data transfers then the waiting fetch
    do_reset();
    i_req = 1; i_adr = 32'h800;
    d_req = 1; d_adr = 32'h2000; d_we = 0;
    seq_d = 0; seq_ok = 1;
    for (int k = 0; k < 5; k++) begin
      serve(0, 1, 0, 32'(k));
      if (biu_adr == 32'h2000) seq_d++;
      else if (seq_d != 4) seq_ok = 0;
      if (k == 4) begin
        chk("as_last_is_i", biu_adr, 32'h800);
        chk("as_streak0", 32'(dut.streak), 32'd0);
      end
      release_biu();
      if (k == 4) begin i_req = 0; d_req = 0; end
    end
    chk("as_dcount", 32'(seq_d), 32'd4);
    chk("as_order", 32'(seq_ok), 32'd1);

    // flush one cycle before the ack
    do_reset();
    i_req = 1; i_adr = 32'h204;
    serve(1, 0, 0, 0);
    i_flush = 1; i_req = 0;
    @(negedge clk); i_flush = 0; biu_ack = 1; biu_q = 32'h77; #1;
    chk("fl_iack", 32'(i_ack), 32'd0);
    chk("fl_ierr", 32'(i_err), 32'd0);
    release_biu(); #1;
    chk("fl_idle", 32'(biu_req), 32'd0);
    i_req = 1; i_adr = 32'h300;
    serve(1, 1, 0, 32'h99);
    chk("fl_next_adr", biu_adr, 32'h300);
    chk("fl_next_ack", 32'(i_ack), 32'd1);
    release_biu(); i_req = 0;

    // flush colliding with the ack
    @(negedge clk); i_req = 1; i_adr = 32'h208;
    serve(1, 1, 0, 32'h11);
    i_flush = 1; #1;
    chk("fc_iack", 32'(i_ack), 32'd0);
    release_biu(); i_flush = 0; i_req = 0;

    // error with ack
    @(negedge clk); d_req = 1; d_adr = 32'h4; d_we = 0;
    serve(1, 1, 1, 0);
    chk("er_derr", 32'(d_err), 32'd1);
    chk("er_dack", 32'(d_ack), 32'd0);
    release_biu(); d_req = 0; #1;
    chk("er_idle", 32'(biu_req), 32'd0);

    // async reset in the middle of a data transfer
    @(negedge clk); d_req = 1; d_adr = 32'h80; d_we = 1; d_d = 32'h1234;
    serve(1, 0, 0, 0);
    #4 rstn = 1'b0; #1;
    chk("ar_req", 32'(biu_req), 32'd0);
    chk("ar_dack", 32'(d_ack), 32'd0);
    chk("ar_derr", 32'(d_err), 32'd0);
    chk("ar_adr", biu_adr, 32'd0);
    d_req = 0;
    @(negedge clk); rstn = 1'b1;
    @(negedge clk); d_req = 1; d_adr = 32'h84; d_we = 0;
    serve(1, 1, 0, 32'hCAFE);
    chk("ar_new_adr", biu_adr, 32'h84);
    chk("ar_new_ack", 32'(d_ack), 32'd1);
    chk("ar_new_q", d_q, 32'hCAFE);
    release_biu(); d_req = 0;

    // randomized traffic
    bcnt = 0; saw_i = 0; saw_d = 0; saw_f = 0;
    repeat (3000) begin
      @(negedge clk);
      if (saw_i || saw_f || !i_req) begin
        i_req = ($urandom_range(0, 2) == 0);
        i_adr = {$urandom_range(0, 16'hFFFF), 2'b00};
      end
      if (saw_d || !d_req) begin
        d_req  = ($urandom_range(0, 2) == 0);
        d_adr  = $urandom;
        d_d    = $urandom;
        d_we   = 1'($urandom);
        d_size = biu_size_t'($urandom_range(0, 2));
      end
      i_flush = i_req && ($urandom_range(0, 11) == 0);
      if (!biu_req) begin
        biu_ack = 0; biu_err = 0;
        bcnt = $urandom_range(0, 3);
      end else if (bcnt == 0) begin
        biu_err = ($urandom_range(0, 4) == 0);
        biu_ack = biu_err ? 1'($urandom) : 1'b1;
        biu_q   = $urandom;
      end else begin
        bcnt--;
      end
      #1;
      saw_i = i_ack | i_err;
      saw_d = d_ack | d_err;
      saw_f = i_flush;
    end

    @(negedge clk);
    i_req = 0; d_req = 0; i_flush = 0; biu_ack = 0; biu_err = 0;
    repeat (3) @(negedge clk);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
